// File: rtl/dump_pkg.sv
// Shared types and sizes for the state-dump record stream (producer and consumer sides).
package dump_pkg;

    localparam int unsigned NUM_REGS = 16;
    localparam int unsigned NUM_BP   = 8;
    localparam int unsigned CYC_W    = 32;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned BP_W     = 3;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned NUM_RECS = 1 + NUM_REGS + 2 * NUM_BP;

    typedef enum logic [1:0] {
        REC_HDR = 2'd0,
        REC_REG = 2'd1,
        REC_BHT = 2'd2,
        REC_BTB = 2'd3
    } rec_kind_t;

    typedef enum logic [2:0] {
        DS_IDLE = 3'd0,
        DS_HDR  = 3'd1,
        DS_REG  = 3'd2,
        DS_BHT  = 3'd3,
        DS_BTB  = 3'd4,
        DS_DONE = 3'd5
    } dump_state_t;

    typedef struct packed {
        rec_kind_t          kind;
        logic [IDX_W-1:0]   idx;
        logic [DATA_W-1:0]  addr;
        logic [DATA_W-1:0]  data;
    } dump_rec_t;

endpackage

// File: rtl/state_dump_streamer.sv
// Walks regfile, BHT and BTB on request and streams one tagged record per entry.
module state_dump_streamer
    import dump_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                dump_req,
    output logic                busy,
    output logic                done,
    output logic [IDX_W-1:0]    rf_raddr,
    input  logic [DATA_W-1:0]   rf_rdata,
    output logic [BP_W-1:0]     bp_idx,
    input  logic [DATA_W-1:0]   bht_pc,
    input  logic [1:0]          bht_pred,
    input  logic                bht_valid,
    input  logic [DATA_W-1:0]   btb_pc,
    input  logic [DATA_W-1:0]   btb_target,
    output logic                rec_valid,
    input  logic                rec_ready,
    output logic [1:0]          rec_kind,
    output logic [IDX_W-1:0]    rec_idx,
    output logic [DATA_W-1:0]   rec_addr,
    output logic [DATA_W-1:0]   rec_data,
    output logic                req_dropped
);

    dump_state_t        state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    dump_rec_t          rec_q, rec_d;
    logic               rec_valid_q, rec_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dropped_q, dropped_d;
    logic [IDX_W-1:0]   rf_raddr_q, rf_raddr_d;
    logic [BP_W-1:0]    bp_idx_q, bp_idx_d;

    dump_state_t        nstate_c;
    logic [IDX_W-1:0]   nidx_c;

    // Next-state, successor record and payload load; read pointers always lead by one entry.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cyc_d       = cyc_q + CYC_W'(1);
        rec_d       = rec_q;
        rec_valid_d = rec_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        dropped_d   = dropped_q;
        rf_raddr_d  = rf_raddr_q;
        bp_idx_d    = bp_idx_q;
        nstate_c    = state_q;
        nidx_c      = idx_q;

        case (state_q)
            DS_IDLE: begin
                if (dump_req) begin
                    state_d     = DS_HDR;
                    idx_d       = '0;
                    rec_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    rec_d.kind  = REC_HDR;
                    rec_d.idx   = '0;
                    rec_d.addr  = cyc_q[CYC_W-1:DATA_W];
                    rec_d.data  = cyc_q[DATA_W-1:0];
                end
            end
            DS_HDR, DS_REG, DS_BHT, DS_BTB: begin
                if (dump_req) begin
                    dropped_d = 1'b1;
                end
                if (rec_valid_q && rec_ready) begin
                    case (state_q)
                        DS_HDR: begin
                            nstate_c = DS_REG;
                            nidx_c   = '0;
                        end
                        DS_REG: begin
                            nstate_c = (idx_q == IDX_W'(NUM_REGS - 1)) ? DS_BHT : DS_REG;
                            nidx_c   = (idx_q == IDX_W'(NUM_REGS - 1)) ? '0 : idx_q + IDX_W'(1);
                        end
                        DS_BHT: begin
                            nstate_c = (idx_q == IDX_W'(NUM_BP - 1)) ? DS_BTB : DS_BHT;
                            nidx_c   = (idx_q == IDX_W'(NUM_BP - 1)) ? '0 : idx_q + IDX_W'(1);
                        end
                        default: begin
                            nstate_c = (idx_q == IDX_W'(NUM_BP - 1)) ? DS_DONE : DS_BTB;
                            nidx_c   = (idx_q == IDX_W'(NUM_BP - 1)) ? '0 : idx_q + IDX_W'(1);
                        end
                    endcase

                    state_d = nstate_c;
                    idx_d   = nidx_c;

                    case (nstate_c)
                        DS_REG: begin
                            rec_d.kind = REC_REG;
                            rec_d.idx  = nidx_c;
                            rec_d.addr = DATA_W'(nidx_c);
                            rec_d.data = rf_rdata;
                            rf_raddr_d = nidx_c + IDX_W'(1);
                        end
                        DS_BHT: begin
                            rec_d.kind = REC_BHT;
                            rec_d.idx  = nidx_c;
                            rec_d.addr = bht_pc;
                            rec_d.data = DATA_W'({bht_valid, bht_pred});
                            bp_idx_d   = BP_W'(nidx_c) + BP_W'(1);
                        end
                        DS_BTB: begin
                            rec_d.kind = REC_BTB;
                            rec_d.idx  = nidx_c;
                            rec_d.addr = btb_pc;
                            rec_d.data = btb_target;
                            bp_idx_d   = BP_W'(nidx_c) + BP_W'(1);
                        end
                        DS_DONE: begin
                            rec_d       = '0;
                            rec_valid_d = 1'b0;
                            busy_d      = 1'b0;
                            done_d      = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            DS_DONE: begin
                if (dump_req) begin
                    dropped_d = 1'b1;
                end
                state_d = DS_IDLE;
            end
            default: begin
                state_d = DS_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; synchronous reset aborts any dump in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= DS_IDLE;
            idx_q       <= '0;
            cyc_q       <= '0;
            rec_q       <= '0;
            rec_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dropped_q   <= 1'b0;
            rf_raddr_q  <= '0;
            bp_idx_q    <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cyc_q       <= cyc_d;
            rec_q       <= rec_d;
            rec_valid_q <= rec_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dropped_q   <= dropped_d;
            rf_raddr_q  <= rf_raddr_d;
            bp_idx_q    <= bp_idx_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign rf_raddr    = rf_raddr_q;
    assign bp_idx      = bp_idx_q;
    assign rec_valid   = rec_valid_q;
    assign rec_kind    = rec_q.kind;
    assign rec_idx     = rec_q.idx;
    assign rec_addr    = rec_q.addr;
    assign rec_data    = rec_q.data;
    assign req_dropped = dropped_q;

endmodule
